load_store_unit: RTL and testbench

//  Memory-access pipeline stage between execute and writeback; sole driver of the 32-word DCache.

---
 rtl/load_store_unit.sv | 198 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-access stage between execute and writeback. It is the only driver
//   of the 32-word DCache. It accepts one request per in_valid/in_ready
//   handshake and checks the byte address. LDR and STR go through the DCache:
//   the cache reads on posedge and writes on negedge. Every other uop passes
//   its in_data straight through. Each result is held on the wb_* port until
//   writeback accepts it.
//
// Ports
//   clock, reset_n              : single clock, synchronous active-low reset
//   in_valid/in_ready           : request handshake from execute
//   in_uop/in_addr/in_data/in_rd: request fields
//   dc_addr/dc_data/dc_uop      : DCache word index, store data, micro-op
//   dc_rdata                    : DCache read data (valid one cycle after read)
//   wb_valid/wb_ready           : result handshake to writeback
//   wb_rd/wb_data/wb_we/wb_fault: result fields
//   ld_count/st_count           : saturating completed LDR/STR counters
module load_store_unit #(
  parameter logic [4:0]  NOP_UOP = 5'd0,
  parameter logic [4:0]  LDR_UOP = 5'd1,
  parameter logic [4:0]  STR_UOP = 5'd2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_uop,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_data,
  input  logic [3:0]       in_rd,
  output logic [4:0]       dc_addr,
  output logic [31:0]      dc_data,
  output logic [4:0]       dc_uop,
  input  logic [31:0]      dc_rdata,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [3:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic             wb_we,
  output logic             wb_fault,
  output logic [CNT_W-1:0] ld_count,
  output logic [CNT_W-1:0] st_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    OUT     = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [4:0]       req_uop_r, req_uop_s;
  logic             in_ready_s;
  logic [4:0]       dc_addr_s;
  logic [31:0]      dc_data_s;
  logic [4:0]       dc_uop_s;
  logic             wb_valid_s;
  logic [3:0]       wb_rd_s;
  logic [31:0]      wb_data_s;
  logic             wb_we_s;
  logic             wb_fault_s;
  logic [CNT_W-1:0] ld_count_s, st_count_s;
  logic             is_mem_s, addr_fault_s;

  // Saturating increment: once all-ones, the counter stays there until reset.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Classify the offered request: memory op or not, and legal word address or not.
  always_comb begin
    is_mem_s     = (in_uop == LDR_UOP) || (in_uop == STR_UOP);
    addr_fault_s = (in_addr[1:0] != 2'b00) || (in_addr[31:7] != 25'd0);
  end

  // Next-state and next-output logic. Every output is registered. The DCache
  // drive registers also hold the request's word index and store data, so
  // they are loaded only when a legal memory op is accepted. Outside ISSUE
  // they fall back to NOP/0.
  always_comb begin
    state_s    = state_r;
    req_uop_s  = req_uop_r;
    dc_uop_s   = NOP_UOP;
    dc_addr_s  = 5'd0;
    dc_data_s  = 32'd0;
    wb_valid_s = wb_valid;
    wb_rd_s    = wb_rd;
    wb_data_s  = wb_data;
    wb_we_s    = wb_we;
    wb_fault_s = wb_fault;
    ld_count_s = ld_count;
    st_count_s = st_count;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          req_uop_s = in_uop;
          wb_rd_s   = in_rd;
          if (is_mem_s && !addr_fault_s) begin
            state_s   = ISSUE;
            dc_uop_s  = in_uop;
            dc_addr_s = in_addr[6:2];
            dc_data_s = in_data;
          end else if (is_mem_s) begin
            state_s    = OUT;
            wb_valid_s = 1'b1;
            wb_data_s  = 32'd0;
            wb_we_s    = 1'b0;
            wb_fault_s = 1'b1;
          end else begin
            state_s    = OUT;
            wb_valid_s = 1'b1;
            wb_data_s  = in_data;
            wb_we_s    = 1'b1;
            wb_fault_s = 1'b0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        // A store was written at this cycle's negedge. A load is registered
        // by the DCache at the edge that ends this cycle.
        if (req_uop_r == STR_UOP) begin
          state_s    = OUT;
          wb_valid_s = 1'b1;
          wb_data_s  = 32'd0;
          wb_we_s    = 1'b0;
          wb_fault_s = 1'b0;
          st_count_s = sat_inc(st_count);
        end else begin
          state_s = CAPTURE;
        end
      end
      CAPTURE: begin
        // dc_rdata holds the loaded word during this cycle only.
        state_s    = OUT;
        wb_valid_s = 1'b1;
        wb_data_s  = dc_rdata;
        wb_we_s    = 1'b1;
        wb_fault_s = 1'b0;
        ld_count_s = sat_inc(ld_count);
      end
      OUT: begin
        if (wb_ready) begin
          state_s    = IDLE;
          wb_valid_s = 1'b0;
        end else begin
          state_s = OUT;
        end
      end
      default: begin
        state_s    = IDLE;
        wb_valid_s = 1'b0;
      end
    endcase
    in_ready_s = (state_s == IDLE);
  end

  // State and output registers. Reset takes priority over every other event.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      req_uop_r <= 5'd0;
      in_ready  <= 1'b1;
      dc_uop    <= NOP_UOP;
      dc_addr   <= 5'd0;
      dc_data   <= 32'd0;
      wb_valid  <= 1'b0;
      wb_rd     <= 4'd0;
      wb_data   <= 32'd0;
      wb_we     <= 1'b0;
      wb_fault  <= 1'b0;
      ld_count  <= {CNT_W{1'b0}};
      st_count  <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_s;
      req_uop_r <= req_uop_s;
      in_ready  <= in_ready_s;
      dc_uop    <= dc_uop_s;
      dc_addr   <= dc_addr_s;
      dc_data   <= dc_data_s;
      wb_valid  <= wb_valid_s;
      wb_rd     <= wb_rd_s;
      wb_data   <= wb_data_s;
      wb_we     <= wb_we_s;
      wb_fault  <= wb_fault_s;
      ld_count  <= ld_count_s;
      st_count  <= st_count_s;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit. A behavioural 32-word DCache is
// attached; it writes on negedge and returns read data one posedge after a
// read. Expected results are queued when a request is accepted. They are
// checked when the result appears on the writeback port.
module tb_load_store_unit;

  localparam logic [4:0] NOP = 5'd0;
  localparam logic [4:0] LDR = 5'd1;
  localparam logic [4:0] STR = 5'd2;
  localparam logic [4:0] ALU = 5'd3;
  localparam int         CW  = 2;
  localparam int         CNT_MAX = (1 << CW) - 1;

  logic          clock;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_uop;
  logic [31:0]   in_addr;
  logic [31:0]   in_data;
  logic [3:0]    in_rd;
  logic [4:0]    dc_addr;
  logic [31:0]   dc_data;
  logic [4:0]    dc_uop;
  logic [31:0]   dc_rdata;
  logic          wb_valid;
  logic          wb_ready;
  logic [3:0]    wb_rd;
  logic [31:0]   wb_data;
  logic          wb_we;
  logic          wb_fault;
  logic [CW-1:0] ld_count;
  logic [CW-1:0] st_count;

  load_store_unit #(
    .NOP_UOP(NOP), .LDR_UOP(LDR), .STR_UOP(STR), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_uop(in_uop),
    .in_addr(in_addr), .in_data(in_data), .in_rd(in_rd),
    .dc_addr(dc_addr), .dc_data(dc_data), .dc_uop(dc_uop), .dc_rdata(dc_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_we(wb_we), .wb_fault(wb_fault), .ld_count(ld_count), .st_count(st_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural DCache.
  logic [31:0] dcache [32];
  always @(negedge clock) begin
    if (dc_uop == STR) dcache[dc_addr] <= dc_data;
  end
  always @(posedge clock) begin
    dc_rdata <= (dc_uop == LDR) ? dcache[dc_addr] : 32'd0;
  end

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        fault;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] shadow [32];
  int          vectors = 0;
  int          miscompares = 0;
  int          exp_ld = 0;
  int          exp_st = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    sb_q.delete();
    exp_ld = 0;
    exp_st = 0;
  endtask

  // Offer one request, push its expected result, and return at #1 after the accept edge.
  task automatic send(input logic [4:0] uop, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] rd);
    int   w;
    logic mem;
    logic flt;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    check("in_ready_before_send", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_uop   = uop;
    in_addr  = addr;
    in_data  = data;
    in_rd    = rd;
    mem = (uop == LDR) || (uop == STR);
    flt = (addr[1:0] != 2'b00) || (addr[31:7] != 25'd0);
    if (mem && flt) begin
      sb_q.push_back('{rd: rd, data: 32'd0, we: 1'b0, fault: 1'b1});
    end else if (uop == STR) begin
      shadow[addr[6:2]] = data;
      exp_st = (exp_st == CNT_MAX) ? CNT_MAX : exp_st + 1;
      sb_q.push_back('{rd: rd, data: 32'd0, we: 1'b0, fault: 1'b0});
    end else if (uop == LDR) begin
      exp_ld = (exp_ld == CNT_MAX) ? CNT_MAX : exp_ld + 1;
      sb_q.push_back('{rd: rd, data: shadow[addr[6:2]], we: 1'b1, fault: 1'b0});
    end else begin
      sb_q.push_back('{rd: rd, data: data, we: 1'b1, fault: 1'b0});
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for wb_valid, compare against the scoreboard, then complete the handshake.
  task automatic get_result(input string tag, input int exp_lat);
    int   lat;
    exp_t e;
    lat = 1;
    while (!wb_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (exp_lat > 0) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
    check({tag, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_wb_rd"}, 32'(wb_rd), 32'(e.rd));
      check({tag, "_wb_data"}, wb_data, e.data);
      check({tag, "_wb_we"}, 32'(wb_we), 32'(e.we));
      check({tag, "_wb_fault"}, 32'(wb_fault), 32'(e.fault));
    end
    wb_ready = 1'b1;
    tick();
    check({tag, "_ld_count"}, 32'(ld_count), 32'(exp_ld));
    check({tag, "_st_count"}, 32'(st_count), 32'(exp_st));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    for (int i = 0; i < 32; i++) begin
      dcache[i] = 32'd0;
      shadow[i] = 32'd0;
    end
    dc_rdata = 32'd0;
    reset_n  = 1'b1;
    in_valid = 1'b0;
    in_uop   = NOP;
    in_addr  = 32'd0;
    in_data  = 32'd0;
    in_rd    = 4'd0;
    wb_ready = 1'b1;

    // Reset state, sampled while reset is still asserted.
    do_reset();
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_we", 32'(wb_we), 32'd0);
    check("rst_wb_fault", 32'(wb_fault), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_ld_count", 32'(ld_count), 32'd0);
    check("rst_st_count", 32'(st_count), 32'd0);
    check("rst_dc_uop", 32'(dc_uop), 32'(NOP));
    check("rst_dc_addr", 32'(dc_addr), 32'd0);
    check("rst_dc_data", dc_data, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;

    // Store, then load the same word.
    send(STR, 32'h0000_0014, 32'hDEAD_BEEF, 4'd1);
    check("str_dc_uop", 32'(dc_uop), 32'(STR));
    check("str_dc_addr", 32'(dc_addr), 32'd5);
    check("str_dc_data", dc_data, 32'hDEAD_BEEF);
    get_result("str14", 2);
    check("idle_dc_uop", 32'(dc_uop), 32'(NOP));

    send(LDR, 32'h0000_0014, 32'd0, 4'd3);
    check("ldr_dc_uop", 32'(dc_uop), 32'(LDR));
    check("ldr_dc_addr", 32'(dc_addr), 32'd5);
    check("ldr_busy_in_ready", 32'(in_ready), 32'd0);
    get_result("ldr14", 3);

    // Illegal addresses: misaligned and out of range.
    send(LDR, 32'h0000_0013, 32'd0, 4'd4);
    check("flt13_dc_uop", 32'(dc_uop), 32'(NOP));
    get_result("flt13", 1);
    send(LDR, 32'h0000_0080, 32'd0, 4'd5);
    check("flt80_dc_uop", 32'(dc_uop), 32'(NOP));
    get_result("flt80", 1);
    send(STR, 32'h8000_0000, 32'h5555_AAAA, 4'd6);
    check("fltstr_dc_uop", 32'(dc_uop), 32'(NOP));
    get_result("fltstr", 1);

    // Pass-through held under writeback backpressure.
    wb_ready = 1'b0;
    send(ALU, 32'hFFFF_FFFF, 32'h0000_1234, 4'd7);
    for (int i = 0; i < 4; i++) begin
      check("hold_wb_valid", 32'(wb_valid), 32'd1);
      check("hold_wb_data", wb_data, 32'h0000_1234);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    get_result("pass", 0);
    check("pass_in_ready_after", 32'(in_ready), 32'd1);

    // Reset while a load is in CAPTURE: the result is dropped and the stored word survives.
    send(STR, 32'h0000_0020, 32'hCAFE_F00D, 4'd8);
    get_result("str20", 2);
    send(LDR, 32'h0000_0020, 32'd0, 4'd9);
    tick();
    do_reset();
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (wb_valid) seen = 1;
      tick();
    end
    check("abort_no_wb_valid", 32'(seen), 32'd0);
    check("abort_ld_count", 32'(ld_count), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    send(LDR, 32'h0000_0020, 32'd0, 4'd10);
    get_result("ldr20", 3);

    // Counter saturation: st_count 1,2,3,3,3.
    do_reset();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(STR, 32'(i * 4), 32'(i + 100), 4'(i));
      get_result("sat_str", 2);
    end
    check("sat_st_final", 32'(st_count), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
